// File: rtl/ctrl_ajuste_updown.sv
// Pushbutton-to-counter step controller: one step on press, then delayed auto-repeat on held
// buttons, with press arbitration, optional 0/MAX saturation and pulse spacing for q_in settling.
module ctrl_ajuste_updown #(
  parameter int N           = 4,
  parameter int MAX         = 9,
  parameter int SAT         = 1,
  parameter int DELAY_TICKS = 8,
  parameter int RATE_TICKS  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         tick,
  input  logic [N-1:0] q_in,
  output logic         enUP,
  output logic         enDOWN,
  output logic         at_lim,
  output logic [1:0]   state
);

  localparam int MAXT = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;

  localparam logic [CW-1:0] DELAY_C = CW'(DELAY_TICKS);
  localparam logic [CW-1:0] RATE_C  = CW'(RATE_TICKS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [N-1:0]  MAX_Q   = N'(MAX);
  localparam bit            SAT_EN  = (SAT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10,
    LOCK   = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          pend_q, pend_d;
  logic          up_d, dn_d;
  logic          step_req, keep, held, other;
  logic          fire, last_pulse, blk_up, blk_dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOCK;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pend_q  <= 1'b0;
      enUP    <= 1'b0;
      enDOWN  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      enUP    <= up_d;
      enDOWN  <= dn_d;
    end
  end

  // keep marks cycles where the press stays valid, so a deferred step may still be issued
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_req = 1'b0;
    keep     = 1'b0;
    held     = dir_q ? btn_up : btn_down;
    other    = dir_q ? btn_down : btn_up;
    unique case (state_q)
      IDLE: begin
        if (btn_up && btn_down) begin
          state_d = LOCK;
        end else if (btn_up || btn_down) begin
          dir_d    = btn_up;
          step_req = 1'b1;
          keep     = 1'b1;
          cnt_d    = DELAY_C;
          state_d  = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!held) begin
          state_d = IDLE;
        end else if (other) begin
          state_d = LOCK;
        end else begin
          keep = 1'b1;
          if (tick) begin
            if (cnt_q == ONE_C) begin
              step_req = 1'b1;
              cnt_d    = RATE_C;
              state_d  = REPEAT;
            end else begin
              cnt_d = cnt_q - ONE_C;
            end
          end
        end
      end
      LOCK: begin
        if (!btn_up && !btn_down) state_d = IDLE;
      end
      default: state_d = LOCK;
    endcase
  end

  // a step landing right after a pulse is held one cycle in pend_q; gating uses q_in at issue
  always_comb begin
    last_pulse = enUP | enDOWN;
    blk_up     = SAT_EN && (q_in >= MAX_Q);
    blk_dn     = SAT_EN && (q_in == '0);
    fire       = keep && (step_req || pend_q);
    pend_d     = 1'b0;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    if (fire) begin
      if (last_pulse) begin
        pend_d = 1'b1;
      end else begin
        up_d = dir_d && !blk_up;
        dn_d = !dir_d && !blk_dn;
      end
    end
  end

  assign at_lim = SAT_EN && ((q_in == '0) || (q_in == MAX_Q));
  assign state  = state_q;

endmodule
